// File: rtl/branch_resolve_if.sv
// ID/EX branch fields into EX and EX/MEM redirect fields out to fetch.
// master drives the ID/EX side; slave is the resolving stage.
interface branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic             id_ex_valid;
  logic [31:0]      id_ex_npc;
  logic [31:0]      id_ex_imm;
  logic [31:0]      id_ex_rs_data;
  logic [31:0]      id_ex_rt_data;
  logic [1:0]       id_ex_branch_op;
  logic             ex_mem_pc_src;
  logic [31:0]      ex_mem_npc;
  logic             ex_mem_valid;
  logic             flush;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output id_ex_valid,
    output id_ex_npc,
    output id_ex_imm,
    output id_ex_rs_data,
    output id_ex_rt_data,
    output id_ex_branch_op,
    input  ex_mem_pc_src,
    input  ex_mem_npc,
    input  ex_mem_valid,
    input  flush,
    input  taken_count
  );

  modport slave (
    input  id_ex_valid,
    input  id_ex_npc,
    input  id_ex_imm,
    input  id_ex_rs_data,
    input  id_ex_rt_data,
    input  id_ex_branch_op,
    output ex_mem_pc_src,
    output ex_mem_npc,
    output ex_mem_valid,
    output flush,
    output taken_count
  );
endinterface

// File: rtl/branch_resolve.sv
// EX-stage BEQ/BNE/J resolution, EX/MEM redirect latch and
// wrong-path squash window after a taken branch.
module branch_resolve #(
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  branch_resolve_if.slave bus
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BEQ  = 2'b01;
  localparam logic [1:0] OP_BNE  = 2'b10;
  localparam logic [1:0] OP_J    = 2'b11;

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             eq;
  logic             cond;
  logic             accept;
  logic             take;
  logic [31:0]      target;

  logic [3:0]       squash_cnt;
  logic             pc_src_q;
  logic [31:0]      npc_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    eq     = (bus.id_ex_rs_data == bus.id_ex_rt_data);
    target = bus.id_ex_npc + bus.id_ex_imm;
    cond   = 1'b0;
    unique case (bus.id_ex_branch_op)
      OP_NONE: cond = 1'b0;
      OP_BEQ:  cond = eq;
      OP_BNE:  cond = ~eq;
      OP_J:    cond = 1'b1;
      default: cond = 1'b0;
    endcase
    accept = bus.id_ex_valid & (squash_cnt == 4'd0);
    take   = accept & cond;
  end

  // squash_cnt doubles as the state: zero is idle, nonzero is the window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      squash_cnt <= 4'd0;
      pc_src_q   <= 1'b0;
      npc_q      <= 32'd0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      valid_q  <= accept;
      pc_src_q <= take;
      if (accept)
        npc_q <= take ? target : bus.id_ex_npc;
      if (squash_cnt != 4'd0)
        squash_cnt <= squash_cnt - 4'd1;
      else if (take)
        squash_cnt <= SQ_LOAD;
      if (take && count_q != CNT_MAX)
        count_q <= count_q + 1'b1;
    end
  end

  assign bus.ex_mem_pc_src = pc_src_q;
  assign bus.ex_mem_npc    = npc_q;
  assign bus.ex_mem_valid  = valid_q;
  assign bus.flush         = (squash_cnt != 4'd0);
  assign bus.taken_count   = count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: main unit plus a narrow-counter
// instance used for the saturation case.
module tb_branch_resolve;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.CNT_W(16)) bus_a ();
  branch_resolve_if #(.CNT_W(2))  bus_b ();

  branch_resolve #(.SQUASH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  branch_resolve #(.SQUASH_CYCLES(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] npc,
                         input logic [31:0] imm, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [1:0] op);
    bus_a.id_ex_valid     = v;
    bus_a.id_ex_npc       = npc;
    bus_a.id_ex_imm       = imm;
    bus_a.id_ex_rs_data   = rs;
    bus_a.id_ex_rt_data   = rt;
    bus_a.id_ex_branch_op = op;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] npc,
                         input logic [1:0] op);
    bus_b.id_ex_valid     = v;
    bus_b.id_ex_npc       = npc;
    bus_b.id_ex_imm       = 32'd4;
    bus_b.id_ex_rs_data   = 32'd0;
    bus_b.id_ex_rt_data   = 32'd0;
    bus_b.id_ex_branch_op = op;
  endtask

  task automatic test_reset();
    drive_a(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    drive_b(1'b0, 32'h0, 2'b00);
    rst = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus_a.ex_mem_pc_src !== 1'b0 || bus_a.ex_mem_valid !== 1'b0 ||
        bus_a.flush !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got src=%b val=%b fl=%b want 0 0 0",
               bus_a.ex_mem_pc_src, bus_a.ex_mem_valid, bus_a.flush);
    end
    tests++;
    if (bus_a.ex_mem_npc !== 32'h0 || bus_a.taken_count !== 16'h0) begin
      fails++;
      $display("FAIL reset_data got npc=%h cnt=%h want 0 0",
               bus_a.ex_mem_npc, bus_a.taken_count);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus_a.flush !== 1'b0 || bus_a.ex_mem_valid !== 1'b0 ||
          bus_a.ex_mem_pc_src !== 1'b0) begin
        fails++;
        $display("FAIL idle_%0d got fl=%b val=%b src=%b want 0 0 0",
                 i, bus_a.flush, bus_a.ex_mem_valid, bus_a.ex_mem_pc_src);
      end
    end
  endtask

  task automatic test_beq_taken();
    drive_a(1'b1, 32'h10, 32'hFFFF_FFFC, 32'd5, 32'd5, 2'b01);
    tick();
    tests++;
    if (bus_a.ex_mem_pc_src !== 1'b1 || bus_a.ex_mem_npc !== 32'h0C ||
        bus_a.ex_mem_valid !== 1'b1 || bus_a.flush !== 1'b1) begin
      fails++;
      $display("FAIL beq_taken got src=%b npc=%h val=%b fl=%b want 1 0000000c 1 1",
               bus_a.ex_mem_pc_src, bus_a.ex_mem_npc,
               bus_a.ex_mem_valid, bus_a.flush);
    end
    // valid taken BEQ in the shadow must be discarded
    drive_a(1'b1, 32'h40, 32'h8, 32'd1, 32'd1, 2'b01);
    tick();
    tests++;
    if (bus_a.ex_mem_valid !== 1'b0 || bus_a.ex_mem_pc_src !== 1'b0 ||
        bus_a.flush !== 1'b1 || bus_a.ex_mem_npc !== 32'h0C) begin
      fails++;
      $display("FAIL beq_shadow1 got val=%b src=%b fl=%b npc=%h want 0 0 1 0000000c",
               bus_a.ex_mem_valid, bus_a.ex_mem_pc_src,
               bus_a.flush, bus_a.ex_mem_npc);
    end
    tick();
    tests++;
    if (bus_a.ex_mem_valid !== 1'b0 || bus_a.ex_mem_pc_src !== 1'b0 ||
        bus_a.flush !== 1'b0) begin
      fails++;
      $display("FAIL beq_shadow2 got val=%b src=%b fl=%b want 0 0 0",
               bus_a.ex_mem_valid, bus_a.ex_mem_pc_src, bus_a.flush);
    end
    tests++;
    if (bus_a.taken_count !== 16'd1) begin
      fails++;
      $display("FAIL beq_count got %0d want 1", bus_a.taken_count);
    end
  endtask

  task automatic test_bne_not_taken();
    drive_a(1'b1, 32'h20, 32'h4, 32'd7, 32'd7, 2'b10);
    tick();
    tests++;
    if (bus_a.ex_mem_pc_src !== 1'b0 || bus_a.ex_mem_npc !== 32'h20 ||
        bus_a.ex_mem_valid !== 1'b1 || bus_a.flush !== 1'b0 ||
        bus_a.taken_count !== 16'd1) begin
      fails++;
      $display("FAIL bne_nt got src=%b npc=%h val=%b fl=%b cnt=%0d want 0 00000020 1 0 1",
               bus_a.ex_mem_pc_src, bus_a.ex_mem_npc, bus_a.ex_mem_valid,
               bus_a.flush, bus_a.taken_count);
    end
    drive_a(1'b1, 32'h24, 32'h4, 32'd7, 32'd8, 2'b10);
    tick();
    tests++;
    if (bus_a.ex_mem_pc_src !== 1'b1 || bus_a.ex_mem_npc !== 32'h28 ||
        bus_a.taken_count !== 16'd2) begin
      fails++;
      $display("FAIL bne_t got src=%b npc=%h cnt=%0d want 1 00000028 2",
               bus_a.ex_mem_pc_src, bus_a.ex_mem_npc, bus_a.taken_count);
    end
    drive_a(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    repeat (2) tick();
  endtask

  task automatic test_shadow();
    drive_a(1'b1, 32'h50, 32'h10, 32'd0, 32'd0, 2'b11);
    tick();
    tests++;
    if (bus_a.ex_mem_pc_src !== 1'b1 || bus_a.ex_mem_npc !== 32'h60 ||
        bus_a.taken_count !== 16'd3) begin
      fails++;
      $display("FAIL shadow_j1 got src=%b npc=%h cnt=%0d want 1 00000060 3",
               bus_a.ex_mem_pc_src, bus_a.ex_mem_npc, bus_a.taken_count);
    end
    drive_a(1'b1, 32'h61, 32'h100, 32'd0, 32'd0, 2'b11);
    tick();
    tests++;
    if (bus_a.ex_mem_pc_src !== 1'b0 || bus_a.ex_mem_npc !== 32'h60 ||
        bus_a.taken_count !== 16'd3 || bus_a.ex_mem_valid !== 1'b0) begin
      fails++;
      $display("FAIL shadow_j2 got src=%b npc=%h cnt=%0d val=%b want 0 00000060 3 0",
               bus_a.ex_mem_pc_src, bus_a.ex_mem_npc,
               bus_a.taken_count, bus_a.ex_mem_valid);
    end
    drive_a(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    tick();
    tests++;
    if (bus_a.flush !== 1'b0 || bus_a.ex_mem_pc_src !== 1'b0) begin
      fails++;
      $display("FAIL shadow_end got fl=%b src=%b want 0 0",
               bus_a.flush, bus_a.ex_mem_pc_src);
    end
  endtask

  task automatic test_passthrough();
    drive_a(1'b1, 32'h30, 32'h8, 32'd1, 32'd1, 2'b00);
    tick();
    tests++;
    if (bus_a.ex_mem_valid !== 1'b1 || bus_a.ex_mem_pc_src !== 1'b0 ||
        bus_a.ex_mem_npc !== 32'h30 || bus_a.flush !== 1'b0) begin
      fails++;
      $display("FAIL nop_pass got val=%b src=%b npc=%h fl=%b want 1 0 00000030 0",
               bus_a.ex_mem_valid, bus_a.ex_mem_pc_src,
               bus_a.ex_mem_npc, bus_a.flush);
    end
    drive_a(1'b0, 32'h99, 32'h8, 32'd1, 32'd1, 2'b11);
    tick();
    tests++;
    if (bus_a.ex_mem_valid !== 1'b0 || bus_a.ex_mem_pc_src !== 1'b0 ||
        bus_a.ex_mem_npc !== 32'h30 || bus_a.flush !== 1'b0 ||
        bus_a.taken_count !== 16'd3) begin
      fails++;
      $display("FAIL invalid_hold got val=%b src=%b npc=%h fl=%b cnt=%0d want 0 0 00000030 0 3",
               bus_a.ex_mem_valid, bus_a.ex_mem_pc_src, bus_a.ex_mem_npc,
               bus_a.flush, bus_a.taken_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seen;
    logic [3:0] want;
    want = 4'b1001;
    drive_a(1'b1, 32'h80, 32'h20, 32'd0, 32'd0, 2'b11);
    for (int i = 0; i < 4; i++) begin
      tick();
      seen[3-i] = bus_a.ex_mem_pc_src;
    end
    tests++;
    if (seen !== want) begin
      fails++;
      $display("FAIL b2b_src got %b want %b", seen, want);
    end
    tests++;
    if (bus_a.taken_count !== 16'd5) begin
      fails++;
      $display("FAIL b2b_count got %0d want 5", bus_a.taken_count);
    end
    drive_a(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    drive_a(1'b1, 32'h90, 32'h4, 32'd0, 32'd0, 2'b11);
    tick();
    tests++;
    if (bus_a.flush !== 1'b1 || bus_a.ex_mem_pc_src !== 1'b1) begin
      fails++;
      $display("FAIL ar_pre got fl=%b src=%b want 1 1",
               bus_a.flush, bus_a.ex_mem_pc_src);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (bus_a.flush !== 1'b0 || bus_a.ex_mem_pc_src !== 1'b0 ||
        bus_a.ex_mem_valid !== 1'b0 || bus_a.ex_mem_npc !== 32'h0 ||
        bus_a.taken_count !== 16'd0) begin
      fails++;
      $display("FAIL ar_clear got fl=%b src=%b val=%b npc=%h cnt=%0d want 0 0 0 0 0",
               bus_a.flush, bus_a.ex_mem_pc_src, bus_a.ex_mem_valid,
               bus_a.ex_mem_npc, bus_a.taken_count);
    end
    tick();
    rst = 1'b1;
    drive_a(1'b1, 32'h70, 32'h4, 32'd0, 32'd0, 2'b00);
    tick();
    tests++;
    if (bus_a.ex_mem_valid !== 1'b1 || bus_a.ex_mem_npc !== 32'h70 ||
        bus_a.flush !== 1'b0) begin
      fails++;
      $display("FAIL ar_after got val=%b npc=%h fl=%b want 1 00000070 0",
               bus_a.ex_mem_valid, bus_a.ex_mem_npc, bus_a.flush);
    end
  endtask

  task automatic test_wrap();
    drive_a(1'b1, 32'hFFFF_FFFF, 32'h1, 32'd0, 32'd0, 2'b11);
    tick();
    tests++;
    if (bus_a.ex_mem_npc !== 32'h0 || bus_a.ex_mem_pc_src !== 1'b1 ||
        bus_a.taken_count !== 16'd1) begin
      fails++;
      $display("FAIL wrap got npc=%h src=%b cnt=%0d want 00000000 1 1",
               bus_a.ex_mem_npc, bus_a.ex_mem_pc_src, bus_a.taken_count);
    end
    drive_a(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00);
    repeat (2) tick();
  endtask

  task automatic test_saturate();
    logic [1:0] want [5];
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      drive_b(1'b1, 32'h100 + 32'(i), 2'b11);
      tick();
      drive_b(1'b0, 32'h0, 2'b00);
      tests++;
      if (bus_b.taken_count !== want[i]) begin
        fails++;
        $display("FAIL sat_%0d got %0d want %0d",
                 i, bus_b.taken_count, want[i]);
      end
      repeat (2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_shadow();
    test_passthrough();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
